rsa_decrypt: RTL and testbench

RSA_DECRYPT -- requirements
Module: rsa_decrypt

---
 rtl/rsa_decrypt.sv | 177 +++++++++++++++++
 tb/tb_rsa_decrypt.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_decrypt.sv
// -----------------------------------------------------------------------------
// rsa_decrypt
//
// Sequential RSA decryptor. It computes plain = cipher^D mod N by scanning the
// D_BITS exponent bits MSB first: one SQUARE cycle per bit, and one MULT cycle
// after each SQUARE whose exponent bit is set. The latency is fixed and does
// not depend on the data.
//
// Optional feature (define RSA_DECRYPT_RANGE_CHECK_EN):
//   When defined, a ciphertext >= N is rejected on the accepting edge. The FSM
//   goes straight to FINISH with error=1 and plain_data=0, and no arithmetic is
//   performed. The default build (macro undefined) has no input check.
//
// Parameters:
//   N       modulus (must be < 4096 so acc fits in 12 bits)
//   D       private exponent
//   D_BITS  number of exponent bits scanned, MSB first
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   start        decrypt request, honoured only in IDLE
//   cipher_data  13-bit ciphertext; bit 12 feeds only the optional range check
//   busy         high during SQUARE/MULT
//   done         one-cycle pulse (FINISH state); plain_data/error valid
//   plain_data   recovered byte, held until the next done
//   error        result (or input) range fault, held until the next done
// -----------------------------------------------------------------------------
module rsa_decrypt #(
    parameter int unsigned N      = 3233,
    parameter int unsigned D      = 2753,
    parameter int unsigned D_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [12:0] cipher_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  plain_data,
    output logic        error
);

    localparam int unsigned IdxW = (D_BITS > 1) ? $clog2(D_BITS) : 1;
    localparam logic [D_BITS-1:0] DVec = D[D_BITS-1:0];
    localparam logic [23:0] NMod = 24'(N);

    // StIdle/StSquare/StMult/StFinish are the IDLE/SQUARE/MULT/FINISH states.
    typedef enum logic [1:0] {
        StIdle,
        StSquare,
        StMult,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [11:0]     acc_q, acc_d;
    logic [11:0]     base_q, base_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      plain_q, plain_d;
    logic            err_q, err_d;

    logic [23:0]     prod;
    logic [11:0]     mod_res;
    logic            load_result;
    logic            range_fault;

    // Bit 12 only matters to the optional range check.
    logic unused_cipher_msb;
    assign unused_cipher_msb = cipher_data[12];

`ifdef RSA_DECRYPT_RANGE_CHECK_EN
    assign range_fault = (32'(cipher_data) >= N);
`else
    assign range_fault = 1'b0;
`endif

    // Full-width product, then reduction; acc stays below N.
    always_comb begin
        prod = '0;
        if (state_q == StMult) begin
            prod = {12'b0, acc_q} * {12'b0, base_q};
        end else begin
            prod = {12'b0, acc_q} * {12'b0, acc_q};
        end
        mod_res = 12'(prod % NMod);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        base_d      = base_q;
        idx_d       = idx_q;
        plain_d     = plain_q;
        err_d       = err_q;
        load_result = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (range_fault) begin
                        state_d = StFinish;
                        plain_d = 8'd0;
                        err_d   = 1'b1;
                    end else begin
                        base_d  = cipher_data[11:0];
                        acc_d   = 12'd1;
                        idx_d   = IdxW'(D_BITS - 1);
                        state_d = StSquare;
                    end
                end
            end
            StSquare: begin
                acc_d = mod_res;
                if (DVec[idx_q]) begin
                    state_d = StMult;
                end else if (idx_q == '0) begin
                    state_d     = StFinish;
                    load_result = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StMult: begin
                acc_d = mod_res;
                if (idx_q == '0) begin
                    state_d     = StFinish;
                    load_result = 1'b1;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = StSquare;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Result is latched from the value being written into acc on FINISH entry.
        if (load_result) begin
            if (mod_res > 12'd255) begin
                plain_d = 8'd0;
                err_d   = 1'b1;
            end else begin
                plain_d = mod_res[7:0];
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            plain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            plain_q <= plain_d;
            err_q   <= err_d;
        end
    end

    assign busy       = (state_q == StSquare) || (state_q == StMult);
    assign done       = (state_q == StFinish);
    assign plain_data = plain_q;
    assign error      = err_q;

endmodule

// File: tb/tb_rsa_decrypt.sv
// -----------------------------------------------------------------------------
// tb_rsa_decrypt
//
// Self-checking bench for rsa_decrypt. Expected results come from a plain
// right-to-left modular exponentiation model; latency is D_BITS + popcount(D).
// Honours RSA_DECRYPT_RANGE_CHECK_EN in its expectations.
// -----------------------------------------------------------------------------
module tb_rsa_decrypt;

    localparam int unsigned N      = 3233;
    localparam int unsigned D      = 2753;
    localparam int unsigned D_BITS = 12;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [12:0] cipher_data;
    logic        busy;
    logic        done;
    logic [7:0]  plain_data;
    logic        error;

    int checks = 0;
    int errors = 0;

    rsa_decrypt #(
        .N      (N),
        .D      (D),
        .D_BITS (D_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cipher_data (cipher_data),
        .busy        (busy),
        .done        (done),
        .plain_data  (plain_data),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint model_pow(input int c);
        longint r, b, e;
        r = 1;
        b = longint'(c % 4096) % N;
        e = longint'(D) & ((longint'(1) << D_BITS) - 1);
        while (e > 0) begin
            if (e[0]) r = (r * b) % N;
            b = (b * b) % N;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic int model_lat(input int c);
        int pc;
        pc = 0;
        for (int i = 0; i < int'(D_BITS); i++) if (((D >> i) & 1) == 1) pc++;
`ifdef RSA_DECRYPT_RANGE_CHECK_EN
        if (c >= int'(N)) return 0;
`endif
        return int'(D_BITS) + pc;
    endfunction

    // Returns {error, plain}.
    function automatic logic [8:0] model_out(input int c);
        longint r;
`ifdef RSA_DECRYPT_RANGE_CHECK_EN
        if (c >= int'(N)) return {1'b1, 8'd0};
`endif
        r = model_pow(c);
        if (r > 255) return {1'b1, 8'd0};
        return {1'b0, r[7:0]};
    endfunction

    // ---------------- stimulus helper (no checking) ----------------
    // lat counts rising edges from the accepting edge to the one after which
    // done is observed; -1 on timeout.
    task automatic run_op(input logic [12:0] c, output int lat, output logic bsy,
                          output logic [7:0] pd, output logic er, output logic tail_ok);
        @(negedge clk);
        start       = 1'b1;
        cipher_data = c;
        @(posedge clk);
        #1;
        start       = 1'b0;
        cipher_data = 13'($urandom);
        bsy = busy;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        pd = plain_data;
        er = error;
        @(posedge clk);
        #1;
        tail_ok = !done && !busy && (plain_data == pd) && (error == er);
    endtask

    task automatic check_op(input string name, input int c);
        int lat;
        logic bsy, er, tail_ok;
        logic [7:0] pd;
        logic [8:0] exp;
        exp = model_out(c);
        run_op(13'(c), lat, bsy, pd, er, tail_ok);
        checks++;
        if (lat !== model_lat(c)) begin
            errors++;
            $display("FAIL %s latency c=%0d got %0d want %0d", name, c, lat, model_lat(c));
        end
        checks++;
        if ({er, pd} !== exp) begin
            errors++;
            $display("FAIL %s result c=%0d got err=%0b plain=%0d want err=%0b plain=%0d",
                     name, c, er, pd, exp[8], exp[7:0]);
        end
        checks++;
        if (bsy !== (model_lat(c) != 0)) begin
            errors++;
            $display("FAIL %s busy_after_accept c=%0d got %0b", name, c, bsy);
        end
        checks++;
        if (tail_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse_hold c=%0d got %0b want 1", name, c, tail_ok);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b1;  // reset must win over start
        cipher_data = 13'd2790;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, plain_data, error} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%0b done=%0b plain=%0d err=%0b want 0",
                     busy, done, plain_data, error);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got busy=%0b done=%0b want 0 0", busy, done);
        end
    endtask

    task automatic test_known_vector();
        int lat;
        logic bsy, er, tail_ok;
        logic [7:0] pd;
        run_op(13'd2790, lat, bsy, pd, er, tail_ok);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL known_2790 latency got %0d want 17", lat);
        end
        checks++;
        if ({er, pd} !== {1'b0, 8'd65}) begin
            errors++;
            $display("FAIL known_2790 result got err=%0b plain=%0d want err=0 plain=65", er, pd);
        end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_zero", 0);
        check_op("b2b_one", 1);
    endtask

    task automatic test_boundaries();
        check_op("result_3232", 3232);
        check_op("cipher_eq_n", 3233);
        check_op("cipher_4095", 4095);
        check_op("cipher_msb", 4096 + 2790);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_op("random", int'($urandom_range(0, 8191)));
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [7:0] pd;
        @(negedge clk);
        start       = 1'b1;
        cipher_data = 13'd2790;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        pd    = 8'hxx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start       = (k == 5);
            cipher_data = (k == 5) ? 13'd1 : 13'd0;
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                pd = plain_data;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ignore_start done_count got %0d want 1", ndone);
        end
        checks++;
        if (pd !== 8'd65) begin
            errors++;
            $display("FAIL ignore_start result got %0d want 65", pd);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        int lat;
        logic bsy, er, tail_ok;
        logic [7:0] pd;
        @(negedge clk);
        start       = 1'b1;
        cipher_data = 13'd2790;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, plain_data, error} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got busy=%0b done=%0b plain=%0d err=%0b want 0",
                     busy, done, plain_data, error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done got %0d active cycles want 0", ndone);
        end
        run_op(13'd2790, lat, bsy, pd, er, tail_ok);
        checks++;
        if ({lat, er, pd} !== {32'd17, 1'b0, 8'd65}) begin
            errors++;
            $display("FAIL mid_reset_restart got lat=%0d err=%0b plain=%0d want 17 0 65",
                     lat, er, pd);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        cipher_data = '0;
        test_reset();
        test_known_vector();
        test_back_to_back();
        test_boundaries();
        test_random();
        test_ignore_start();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
